// File: rtl/vend_dispense_arbiter_if.sv
// Handshake bundle between the dispense arbiter, the lane debouncers/money accumulator and the motor drivers.
// With VEND_JAM_DETECT_EN defined the bundle also carries vend_sensor (in) and jam (out).
interface vend_dispense_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] stock_empty;
  logic               credit_ok;
  logic [NUM_REQ-1:0] motor_on;
  logic               credit_clr;
  logic               busy;
  logic               sold_out;
`ifdef VEND_JAM_DETECT_EN
  logic               vend_sensor;
  logic               jam;

  modport master (
    output req, stock_empty, credit_ok, vend_sensor,
    input  motor_on, credit_clr, busy, sold_out, jam
  );
  modport slave (
    input  req, stock_empty, credit_ok, vend_sensor,
    output motor_on, credit_clr, busy, sold_out, jam
  );
`else
  modport master (
    output req, stock_empty, credit_ok,
    input  motor_on, credit_clr, busy, sold_out
  );
  modport slave (
    input  req, stock_empty, credit_ok,
    output motor_on, credit_clr, busy, sold_out
  );
`endif
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin vend arbiter: latches lane presses, grants one timed motor pulse per credit, then cools down.
// Optional VEND_JAM_DETECT_EN: product-drop sensor ends pulses early; a pulse without it locks into JAM.
module vend_dispense_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int PULSE_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 25000000
) (
  input logic                    clk,
  input logic                    rst_n,
  vend_dispense_arbiter_if.slave bus
);
  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, DISPENSE, CLEAR, COOLDOWN, JAM} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] req_prev_q, req_prev_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sold_out_q, sold_out_d;

  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_mask;
  logic [PTR_W-1:0]   winner;
  logic               grant_now;
  logic               sensor_hit;

`ifdef VEND_JAM_DETECT_EN
  assign sensor_hit = bus.vend_sensor;
`else
  assign sensor_hit = 1'b0;
`endif

  // First eligible lane at or after ptr, wrapping past the last lane.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0]   pick;
    logic [NUM_REQ-1:0] rot;
    logic               found;
    int                 idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      rot = elig >> idx;
      if (!found && rot[0]) begin
        pick  = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_prev_q <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      sold_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_prev_q <= req_prev_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      sold_out_q <= sold_out_d;
    end
  end

  always_comb begin
    rise       = bus.req & ~req_prev_q;
    eligible   = pending_q & ~bus.stock_empty;
    winner     = rr_pick(eligible, rr_ptr_q);
    grant_now  = (state_q == IDLE) && (eligible != '0) && bus.credit_ok;
    grant_mask = grant_now ? (ONE << winner) : '0;

    // Capture runs in every state; an empty lane rejects new presses and drops stale ones.
    req_prev_d = bus.req;
    pending_d  = (pending_q | rise) & ~bus.stock_empty & ~grant_mask;
    sold_out_d = |((rise | pending_q) & bus.stock_empty);

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          state_d  = DISPENSE;
          grant_d  = winner;
          rr_ptr_d = (winner == PTR_LAST) ? '0 : winner + 1'b1;
          cnt_d    = '0;
        end
      end
      DISPENSE: begin
        if (sensor_hit) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (cnt_q == PULSE_LAST) begin
`ifdef VEND_JAM_DETECT_EN
          state_d = JAM;
`else
          state_d = CLEAR;
`endif
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        state_d = COOLDOWN;
        cnt_d   = '0;
      end
      COOLDOWN: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      JAM:     state_d = JAM;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.motor_on   = '0;
    bus.credit_clr = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.sold_out   = sold_out_q;
    if (state_q == DISPENSE) bus.motor_on = ONE << grant_q;
    if (state_q == CLEAR)    bus.credit_clr = 1'b1;
`ifdef VEND_JAM_DETECT_EN
    bus.jam = (state_q == JAM);
`endif
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Scoreboard bench for vend_dispense_arbiter (NUM_REQ=2, PULSE=4, GAP=2), directed scenarios plus random traffic.
// Honours VEND_JAM_DETECT_EN: drives the drop sensor and exercises the jam lock-up.
module tb_vend_dispense_arbiter;
  localparam int N = 2;
  localparam int P = 4;
  localparam int G = 2;
`ifdef VEND_JAM_DETECT_EN
  localparam bit JAM_BUILD = 1'b1;
`else
  localparam bit JAM_BUILD = 1'b0;
`endif

  typedef struct {
    int lane;
    int start;
    int len;
  } vend_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   sensor_en = 1'b1;

  vend_t q_motor[$];
  int    q_clr[$];
  int    q_idle[$];
  int    q_sold[$];

  // Reference model state: pending set, rr pointer, time at which the mechanism is free again.
  bit pend[N];
  bit prevr[N];
  int ptr;
  int idle_at;
  bit jammed;

  vend_dispense_arbiter_if #(.NUM_REQ(N)) bus ();

  vend_dispense_arbiter #(
    .NUM_REQ(N),
    .PULSE_CYCLES(P),
    .GAP_CYCLES(G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      pend[j]  = 1'b0;
      prevr[j] = 1'b0;
    end
    ptr     = 0;
    idle_at = 0;
    jammed  = 1'b0;
  endtask

  task automatic model_step(input int n, input logic [N-1:0] r, input logic [N-1:0] se, input logic ok);
    int    w;
    int    i;
    int    len;
    bit    sold;
    bit    oldp[N];
    vend_t v;
    w    = -1;
    sold = 1'b0;
    if (!jammed && n >= idle_at && ok) begin
      for (int k = 0; k < N; k++) begin
        i = (ptr + k) % N;
        if (w < 0 && pend[i] && !bitof(se, i)) w = i;
      end
    end
    oldp = pend;
    for (int j = 0; j < N; j++) begin
      bit rs;
      rs = bitof(r, j) && !prevr[j];
      if ((rs || oldp[j]) && bitof(se, j)) begin
        sold    = 1'b1;
        pend[j] = 1'b0;
      end else if (rs) begin
        pend[j] = 1'b1;
      end
      prevr[j] = bitof(r, j);
    end
    if (sold) q_sold.push_back(n + 1);
    if (w >= 0) begin
      len     = (JAM_BUILD && sensor_en) ? 2 : P;
      v.lane  = w;
      v.start = n + 1;
      v.len   = len;
      q_motor.push_back(v);
      pend[w] = 1'b0;
      ptr     = (w + 1) % N;
      if (JAM_BUILD && !sensor_en) begin
        jammed = 1'b1;
      end else begin
        q_clr.push_back(n + 1 + len);
        idle_at = n + 2 + len + G;
        q_idle.push_back(idle_at);
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] se, input logic ok);
    @(posedge clk);
    #2;
    bus.req         = r;
    bus.stock_empty = se;
    bus.credit_ok   = ok;
    model_step(cyc, r, se, ok);
  endtask

  task automatic idle_ticks(input int k, input logic ok);
    for (int c = 0; c < k; c++) tick(2'b00, 2'b00, ok);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_motor_left"}, q_motor.size(), 0);
    check({tag, "_clr_left"},   q_clr.size(),   0);
    check({tag, "_idle_left"},  q_idle.size(),  0);
    check({tag, "_sold_left"},  q_sold.size(),  0);
  endtask

  // Monitor: pops expected events whenever the DUT shows one.
  initial begin : monitor
    logic [N-1:0] pm;
    logic         pb;
    bit           have;
    int           st;
    vend_t        e;
    pm = '0; pb = 1'b0; have = 1'b0; st = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pm = '0; pb = 1'b0; have = 1'b0;
      end else begin
        if (bus.motor_on != '0 && pm == '0) begin
          st = cyc;
          if (q_motor.size() == 0) begin
            check("motor_unexpected", 32'(bus.motor_on), 0);
            have = 1'b0;
          end else begin
            e = q_motor[0];
            check("motor_lane", 32'(bus.motor_on), 1 << e.lane);
            check("motor_start", cyc, e.start);
            have = 1'b1;
          end
        end else if (bus.motor_on == '0 && pm != '0) begin
          if (have) begin
            e = q_motor.pop_front();
            check("motor_len", cyc - st, e.len);
          end
          have = 1'b0;
        end else if (bus.motor_on != pm) begin
          check("motor_changed", 32'(bus.motor_on), 32'(pm));
        end
        if (bus.credit_clr) begin
          if (q_clr.size() == 0) check("clr_unexpected", 1, 0);
          else check("clr_cycle", cyc, q_clr.pop_front());
        end
        if (bus.sold_out) begin
          if (q_sold.size() == 0) check("sold_unexpected", 1, 0);
          else check("sold_cycle", cyc, q_sold.pop_front());
        end
        if (pb && !bus.busy) begin
          if (q_idle.size() == 0) check("idle_unexpected", 1, 0);
          else check("idle_cycle", cyc, q_idle.pop_front());
        end
        pm = bus.motor_on;
        pb = bus.busy;
      end
    end
  end

`ifdef VEND_JAM_DETECT_EN
  // Product drops during the second motor cycle while sensor_en is set.
  initial begin : sensor_drv
    int run;
    run = 0;
    bus.vend_sensor = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.motor_on != '0) run++;
      else run = 0;
      bus.vend_sensor = sensor_en && (run == 2);
    end
  end
`endif

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [N-1:0] r;
    logic [N-1:0] se;
    logic         ok;
    bus.req = '0; bus.stock_empty = '0; bus.credit_ok = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_motor_on", 32'(bus.motor_on), 0);
    check("rst_credit_clr", 32'(bus.credit_clr), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_sold_out", 32'(bus.sold_out), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single press on lane 1 with credit.
    tick(2'b00, 2'b00, 1'b1);
    tick(2'b10, 2'b00, 1'b1);
    idle_ticks(12, 1'b1);

    // Simultaneous presses, one vend per credit.
    tick(2'b11, 2'b00, 1'b1);
    idle_ticks(12, 1'b0);
    idle_ticks(12, 1'b1);
    tick(2'b11, 2'b00, 1'b1);
    idle_ticks(12, 1'b0);
    idle_ticks(12, 1'b1);

    // No credit: press is held until credit arrives.
    tick(2'b01, 2'b00, 1'b0);
    idle_ticks(10, 1'b0);
    check("nocredit_busy", 32'(bus.busy), 0);
    idle_ticks(12, 1'b1);

    // Empty lane rejects; a held button vends only once.
    tick(2'b01, 2'b01, 1'b1);
    for (int c = 0; c < 3; c++) tick(2'b00, 2'b01, 1'b1);
    for (int c = 0; c < 15; c++) tick(2'b01, 2'b00, 1'b1);
    idle_ticks(10, 1'b1);

    // Randomised traffic.
    r = '0; se = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) r[0] = ~r[0];
      if ($urandom_range(0, 3) == 0) r[1] = ~r[1];
      if (se[0]) begin
        if ($urandom_range(0, 3) == 0) se[0] = 1'b0;
      end else if ($urandom_range(0, 39) == 0) se[0] = 1'b1;
      if (se[1]) begin
        if ($urandom_range(0, 3) == 0) se[1] = 1'b0;
      end else if ($urandom_range(0, 39) == 0) se[1] = 1'b1;
      ok = ($urandom_range(0, 2) != 0);
      tick(r, se, ok);
    end
    idle_ticks(20, 1'b0);
    check_drained("random");

    // Asynchronous reset in the second motor cycle with another lane still pending.
    tick(2'b11, 2'b00, 1'b1);
    tick(2'b00, 2'b00, 1'b1);
    tick(2'b00, 2'b00, 1'b1);
    @(posedge clk);
    #2;
    check("midrst_motor_before", 32'(bus.motor_on != '0), 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_motor_on", 32'(bus.motor_on), 0);
    check("midrst_credit_clr", 32'(bus.credit_clr), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    q_motor.delete(); q_clr.delete(); q_idle.delete(); q_sold.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    idle_ticks(15, 1'b1);
    check("midrst_busy_after", 32'(bus.busy), 0);

`ifdef VEND_JAM_DETECT_EN
    // No drop sensed: mechanism locks up and refuses further grants.
    sensor_en = 1'b0;
    tick(2'b01, 2'b00, 1'b1);
    idle_ticks(10, 1'b1);
    check("jam_flag", 32'(bus.jam), 32'(jammed));
    check("jam_busy", 32'(bus.busy), 1);
    tick(2'b10, 2'b00, 1'b1);
    idle_ticks(10, 1'b1);
    check("jam_flag_held", 32'(bus.jam), 32'(jammed));
`endif

    idle_ticks(10, 1'b0);
    check_drained("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
